// File: rtl/top_dp_switch_debounce.sv
// Switch debouncer: 2-flop synchronizer, per-bit stability counter,
// registered debounced level plus rise/fall/changed pulses.
module top_dp_switch_debounce #(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0]                sync1_q;
  logic [WIDTH-1:0]                sync2_q;
  logic [WIDTH-1:0]                lvl_q, lvl_d;
  logic [WIDTH-1:0]                rise_q, rise_d;
  logic [WIDTH-1:0]                fall_q, fall_d;
  logic                            chg_q, chg_d;
  logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // A bit is accepted once its mismatch has been seen on
  // DEBOUNCE_CYCLES consecutive edges; any match restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        cnt_d[i]  = '0;
        lvl_d[i]  = sync2_q[i];
        rise_d[i] = sync2_q[i];
        fall_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
    chg_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      lvl_q  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign sw_out     = lvl_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = chg_q;

endmodule

// File: tb/tb_top_dp_switch_debounce.sv
// Bench for top_dp_switch_debounce: sliding-window model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_top_dp_switch_debounce;

  localparam int D = 4;
  localparam int W = 2;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] sw_out, sw_rise, sw_fall;
  logic         sw_changed;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  top_dp_switch_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .sw_out(sw_out), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sync2 is raw delayed by two edges; a bit flips when the
  // last D sync2 samples since reset all differ from its level.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [W-1:0] m_rise = '0, m_fall = '0;
  logic         m_chg = 1'b0;
  logic [W-1:0] hist[$];

  always @(posedge clk or negedge reset_n) begin
    int run;
    if (!reset_n) begin
      m_s1 = RV; m_s2 = RV; m_lvl = RV;
      m_rise = '0; m_fall = '0; m_chg = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        run = 0;
        foreach (hist[k]) if (hist[k][b] != m_lvl[b]) run++;
        if (run == D) begin
          m_lvl[b] = ~m_lvl[b];
          if (m_lvl[b]) m_rise[b] = 1'b1;
          else          m_fall[b] = 1'b1;
        end
      end
      m_chg = |{m_rise, m_fall};
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model sw_out",     32'(sw_out),     32'(m_lvl));
      chk("model sw_rise",    32'(sw_rise),    32'(m_rise));
      chk("model sw_fall",    32'(sw_fall),    32'(m_fall));
      chk("model sw_changed", 32'(sw_changed), 32'(m_chg));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] bseq [6];

  initial begin
    raw_in  = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst sw_out",  32'(sw_out),     0);
    chk("rst sw_rise", 32'(sw_rise),    0);
    chk("rst sw_fall", 32'(sw_fall),    0);
    chk("rst chg",     32'(sw_changed), 0);
    chk_on = 1;
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // glitch of 3 cycles on bit 0
    raw_in = 2'b01;
    tick(3);
    raw_in = 2'b00;
    tick(10);
    chk("glitch sw_out", 32'(sw_out), 0);

    // clean step 00 -> 01
    raw_in = 2'b01;
    tick(5);
    chk("step E5 sw_out", 32'(sw_out), 0);
    tick(1);
    chk("step E6 sw_out", 32'(sw_out), 1);
    chk("step E6 rise",   32'(sw_rise), 1);
    chk("step E6 fall",   32'(sw_fall), 0);
    chk("step E6 chg",    32'(sw_changed), 1);
    tick(1);
    chk("step E7 rise", 32'(sw_rise), 0);
    chk("step E7 chg",  32'(sw_changed), 0);
    tick(5);

    // simultaneous 01 -> 10
    raw_in = 2'b10;
    tick(5);
    chk("simul E5 sw_out", 32'(sw_out), 1);
    tick(1);
    chk("simul E6 sw_out", 32'(sw_out), 2);
    chk("simul E6 rise",   32'(sw_rise), 2);
    chk("simul E6 fall",   32'(sw_fall), 1);
    chk("simul E6 chg",    32'(sw_changed), 1);
    tick(1);
    chk("simul E7 chg", 32'(sw_changed), 0);
    tick(5);

    raw_in = 2'b00;
    tick(10);
    chk("settle 00", 32'(sw_out), 0);

    // bounce on bit 1: 1,0,1,1,1,1
    bseq[0] = 2'b10; bseq[1] = 2'b00; bseq[2] = 2'b10;
    bseq[3] = 2'b10; bseq[4] = 2'b10; bseq[5] = 2'b10;
    for (int i = 0; i < 6; i++) begin
      raw_in = bseq[i];
      tick(1);
    end
    tick(1);
    chk("bounce E7 sw_out", 32'(sw_out), 0);
    tick(1);
    chk("bounce E8 sw_out", 32'(sw_out), 2);
    chk("bounce E8 rise",   32'(sw_rise), 2);
    tick(1);
    chk("bounce E9 rise", 32'(sw_rise), 0);
    tick(5);

    // reset mid-count
    raw_in = 2'b11;
    tick(4);
    reset_n = 1'b0;
    #1;
    chk("midrst sw_out", 32'(sw_out),     0);
    chk("midrst rise",   32'(sw_rise),    0);
    chk("midrst fall",   32'(sw_fall),    0);
    chk("midrst chg",    32'(sw_changed), 0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    chk("rel E5 sw_out", 32'(sw_out), 0);
    tick(1);
    chk("rel E6 sw_out", 32'(sw_out), 3);
    chk("rel E6 rise",   32'(sw_rise), 3);
    chk("rel E6 chg",    32'(sw_changed), 1);
    tick(5);

    // falling step 11 -> 00
    raw_in = 2'b00;
    tick(5);
    chk("fall E5 sw_out", 32'(sw_out), 3);
    tick(1);
    chk("fall E6 sw_out", 32'(sw_out), 0);
    chk("fall E6 fall",   32'(sw_fall), 3);
    chk("fall E6 rise",   32'(sw_rise), 0);
    chk("fall E6 chg",    32'(sw_changed), 1);
    tick(1);
    chk("fall E7 fall", 32'(sw_fall), 0);

    // random bouncing, model-checked only
    repeat (120) begin
      raw_in = W'($urandom_range(0, 3));
      tick($urandom_range(1, 7));
    end
    tick(10);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
